// File: rtl/imm_decode_ctrl_pkg.sv
// Shared types and constants for the decode-stage controller: opcodes,
// immediate-format selects, the decoded-control bundle and the buffered entry.
package imm_decode_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned IMM_W = 12;

  localparam logic [OPC_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IALU  = 7'b0010011;

  localparam logic IMM_I = 1'b0;
  localparam logic IMM_S = 1'b1;

  typedef struct packed {
    logic imm_src;
    logic reg_write;
    logic mem_write;
    logic alu_src;
    logic result_src;
    logic illegal;
  } ctrl_t;

  // One buffered instruction with everything decoded on entry
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] imm;
    ctrl_t           ctrl;
  } entry_t;

  // Immediate extender: picks the I- or S-format field and sign-extends it
  function automatic logic [XLEN-1:0] imm_extend(input logic [IMM_W-1:0] i_field,
                                                 input logic [IMM_W-1:0] s_field,
                                                 input logic             imm_src);
    logic [IMM_W-1:0] field;
    field = (imm_src == IMM_S) ? s_field : i_field;
    return {{(XLEN-IMM_W){field[IMM_W-1]}}, field};
  endfunction

endpackage

// File: rtl/imm_main_decoder.sv
// Main decoder: maps an RV32 opcode to the decoded-control bundle.
module imm_main_decoder
  import imm_decode_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_t            ctrl_o
);

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.imm_src = IMM_I;
    case (opcode_i)
      OP_LOAD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.imm_src   = IMM_S;
      end
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
      end
      OP_IALU: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Registered decode stage: decodes on entry, then presents results from an
// output register backed by a skid entry so back-pressure never drops work.
module imm_decode_ctrl
  import imm_decode_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [XLEN-1:0]  instr_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [XLEN-1:0]  instr_out,
  output logic             imm_src,
  output logic [XLEN-1:0]  imm_ext,
  output logic             reg_write,
  output logic             mem_write,
  output logic             alu_src,
  output logic             result_src,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic             head_v_q, head_v_d;
  logic             skid_v_q, skid_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t  in_ctrl;
  entry_t in_entry;
  logic   in_xfer;
  logic   out_xfer;

  imm_main_decoder u_main_decoder (
    .opcode_i (instr_in[OPC_W-1:0]),
    .ctrl_o   (in_ctrl)
  );

  always_comb begin
    in_entry.instr = instr_in;
    in_entry.ctrl  = in_ctrl;
    in_entry.imm   = imm_extend(instr_in[31:20],
                                {instr_in[31:25], instr_in[11:7]},
                                in_ctrl.imm_src);
  end

  // ready_out is the registered inverse of skid occupancy, never a path from ready_in
  assign in_xfer  = valid_in && !skid_v_q;
  assign out_xfer = head_v_q && ready_in;

  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    cnt_d    = cnt_q;
    if (flush) begin
      head_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (in_xfer && in_entry.ctrl.illegal && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (out_xfer || !head_v_q) begin
        // Head is free this edge: refill from skid first to keep order
        if (skid_v_q) begin
          head_d   = skid_q;
          head_v_d = 1'b1;
          skid_v_d = 1'b0;
        end else if (in_xfer) begin
          head_d   = in_entry;
          head_v_d = 1'b1;
        end else begin
          head_v_d = 1'b0;
        end
      end else if (in_xfer) begin
        skid_d   = in_entry;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      head_q   <= head_d;
      skid_q   <= skid_d;
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready_out   = !skid_v_q;
  assign valid_out   = head_v_q;
  assign instr_out   = head_q.instr;
  assign imm_ext     = head_q.imm;
  assign imm_src     = head_q.ctrl.imm_src;
  assign reg_write   = head_q.ctrl.reg_write;
  assign mem_write   = head_q.ctrl.mem_write;
  assign alu_src     = head_q.ctrl.alu_src;
  assign result_src  = head_q.ctrl.result_src;
  assign illegal     = head_q.ctrl.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Bench for imm_decode_ctrl: directed scenarios plus random traffic checked
// against a 2-deep queue model of the decode stage.
module tb_imm_decode_ctrl;

  localparam int CNT_W   = 8;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [31:0]      instr_in;
  logic             valid_in;
  logic             ready_out;
  logic             valid_out;
  logic             ready_in;
  logic [31:0]      instr_out;
  logic             imm_src;
  logic [31:0]      imm_ext;
  logic             reg_write;
  logic             mem_write;
  logic             alu_src;
  logic             result_src;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  imm_decode_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .instr_in    (instr_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .instr_out   (instr_out),
    .imm_src     (imm_src),
    .imm_ext     (imm_ext),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .alu_src     (alu_src),
    .result_src  (result_src),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [31:0] q[$];
  int          exp_cnt;
  bit          model_ok;

  // Expected controls {imm_src, reg_write, mem_write, alu_src, result_src, illegal}
  function automatic logic [5:0] exp_ctrl(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'h03) return 6'b010110;
    if (op == 7'h23) return 6'b101100;
    if (op == 7'h33) return 6'b010000;
    if (op == 7'h13) return 6'b010100;
    return 6'b000001;
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] ins, input logic s_fmt);
    logic signed [11:0] f;
    int v;
    f = s_fmt ? {ins[31:25], ins[11:7]} : ins[31:20];
    v = int'(f);
    return 32'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [5:0] c;
    chk("valid_out", 32'(valid_out), 32'(q.size() > 0));
    chk("ready_out", 32'(ready_out), 32'(q.size() < 2));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(exp_cnt));
    if (q.size() > 0) begin
      c = exp_ctrl(q[0]);
      chk("instr_out", instr_out, q[0]);
      chk("imm_ext", imm_ext, exp_imm(q[0], c[5]));
      chk("ctrl", 32'({imm_src, reg_write, mem_write, alu_src, result_src, illegal}), 32'(c));
    end
  endtask

  task automatic model_step(input logic v, input logic [31:0] ins, input logic rdy,
                            input logic fl, input logic rs);
    bit acc;
    logic [5:0] c;
    acc = v && (q.size() < 2);
    if (!rs) begin
      q.delete();
      exp_cnt  = 0;
      model_ok = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (acc) begin
        q.push_back(ins);
        c = exp_ctrl(ins);
        if (c[0] && exp_cnt < CNT_TOP) exp_cnt++;
      end
    end
  endtask

  // One clock: drive, check state before the edge, advance model with the edge
  task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy,
                       input logic fl, input logic rs);
    valid_in = v; instr_in = ins; ready_in = rdy; flush = fl; rst = rs;
    #1;
    if (model_ok) check_model();
    @(posedge clk);
    model_step(v, ins, rdy, fl, rs);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " valid_out"}, 32'(valid_out), 32'd0);
    chk({tag, " ready_out"}, 32'(ready_out), 32'd1);
    chk({tag, " instr_out"}, instr_out, 32'd0);
    chk({tag, " imm_ext"}, imm_ext, 32'd0);
    chk({tag, " ctrl"}, 32'({imm_src, reg_write, mem_write, alu_src, result_src, illegal}), 32'd0);
    chk({tag, " illegal_cnt"}, 32'(illegal_cnt), 32'd0);
  endtask

  localparam logic [31:0] I_LW  = 32'h00812283;
  localparam logic [31:0] I_SW  = 32'hFE512E23;
  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_ADI = 32'hFFF10093;
  localparam logic [31:0] I_BEQ = 32'h00000063;

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    int          cnt_before;
    n_vec = 0; n_err = 0; exp_cnt = 0; model_ok = 1'b0;
    valid_in = 1'b0; instr_in = '0; ready_in = 1'b0; flush = 1'b0; rst = 1'b0;

    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    check_all_zero("reset");

    // Load then store, drained immediately
    cycle(1, I_LW, 1, 0, 1);
    chk("lw imm_ext", imm_ext, 32'h00000008);
    chk("lw ctrl", 32'({imm_src, reg_write, mem_write, alu_src, result_src}), 32'b01011);
    cycle(1, I_SW, 1, 0, 1);
    chk("sw imm_ext", imm_ext, 32'hFFFFFFFC);
    chk("sw ctrl", 32'({imm_src, reg_write, mem_write, alu_src, result_src}), 32'b10110);
    cycle(0, '0, 1, 0, 1);

    // Back-pressure: A, B accepted, C held off until room appears
    cycle(1, I_ADD, 0, 0, 1);
    cycle(1, I_ADI, 0, 0, 1);
    chk("bp ready_out low", 32'(ready_out), 32'd0);
    cycle(1, I_LW, 0, 0, 1);
    cycle(1, I_LW, 0, 0, 1);
    chk("bp head A", instr_out, I_ADD);
    cycle(1, I_LW, 1, 0, 1);
    chk("bp head B", instr_out, I_ADI);
    cycle(1, I_LW, 1, 0, 1);
    chk("bp head C", instr_out, I_LW);
    cycle(0, '0, 1, 0, 1);
    chk("bp drained", 32'(valid_out), 32'd0);

    // Flush with both entries full and an illegal instruction offered
    cycle(1, I_SW, 0, 0, 1);
    cycle(1, I_ADD, 0, 0, 1);
    cnt_before = exp_cnt;
    cycle(1, I_BEQ, 0, 1, 1);
    chk("flush valid_out", 32'(valid_out), 32'd0);
    chk("flush ready_out", 32'(ready_out), 32'd1);
    chk("flush illegal_cnt", 32'(illegal_cnt), 32'(cnt_before));

    // Illegal opcode saturation
    for (int i = 0; i < 300; i++) cycle(1, I_BEQ, 1, 0, 1);
    cycle(0, '0, 1, 0, 1);
    chk("illegal_cnt saturated", 32'(illegal_cnt), 32'd255);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom();
      case ($urandom_range(0, 4))
        0: op = 7'h03;
        1: op = 7'h23;
        2: op = 7'h33;
        3: op = 7'h13;
        default: op = 7'($urandom());
      endcase
      cycle($urandom_range(0, 3) != 0, {r[31:7], op}, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0, 1'b1);
    end

    // Reset mid-stream with both entries full
    cycle(0, '0, 1, 1, 1);
    cycle(1, I_SW, 0, 0, 1);
    cycle(1, I_BEQ, 0, 0, 1);
    chk("pre-reset ready_out", 32'(ready_out), 32'd0);
    cycle(1, I_LW, 0, 0, 0);
    check_all_zero("mid reset");
    cycle(1, I_ADI, 1, 0, 1);
    cycle(0, '0, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
